// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_if
// Brief    : Requester-side and RAM-side signal bundle for ram_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef WORDSIZE
`define WORDSIZE 8
`endif

interface ram_arbiter_if #(
    parameter int DATA_W = `WORDSIZE,
    parameter int ADDR_W = 2
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              done0;
    logic              done1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    // master: the requesters plus the RAM; slave: the arbiter itself
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
        input  ram_addr, ram_wdata, ram_we
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, busy,
        output ram_addr, ram_wdata, ram_we
    );
endinterface

`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Two-port round-robin arbiter/sequencer for a single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef WORDSIZE
`define WORDSIZE 8
`endif

module ram_arbiter #(
    parameter int DATA_W = `WORDSIZE,
    parameter int ADDR_W = 2
) (
    input  wire logic    clk,
    input  wire logic    clr,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_last;
    logic              r_owner;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_busy;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;

    logic              w_any;
    logic              w_pick;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // On a tie the port that was not granted last wins
    assign w_any   = bus.req0 | bus.req1;
    assign w_pick  = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    assign w_we    = w_pick ? bus.we1    : bus.we0;
    assign w_addr  = w_pick ? bus.addr1  : bus.addr0;
    assign w_wdata = w_pick ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_busy      <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    if (w_any) begin
                        r_state     <= S_ACCESS;
                        r_owner     <= w_pick;
                        r_last      <= w_pick;
                        r_gnt0      <= ~w_pick;
                        r_gnt1      <= w_pick;
                        r_busy      <= 1'b1;
                        r_ram_we    <= w_we;
                        r_ram_addr  <= w_addr;
                        r_ram_wdata <= w_wdata;
                    end
                end
                S_ACCESS: begin
                    r_state  <= S_RESP;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_ram_we <= 1'b0;
                    r_done0  <= ~r_owner;
                    r_done1  <= r_owner;
                    // r_ram_we still holds the access direction here
                    if (!r_ram_we) begin
                        if (r_owner) r_rdata1 <= bus.ram_rdata;
                        else         r_rdata0 <= bus.ram_rdata;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_done0  <= 1'b0;
                    r_done1  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_ram_we <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt0      = r_gnt0;
    assign bus.gnt1      = r_gnt1;
    assign bus.done0     = r_done0;
    assign bus.done1     = r_done1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.busy      = r_busy;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter with a 4x8 RAM model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_ram_arbiter;

    logic clk;
    logic clr;
    logic [7:0] mem [4];
    int n_pass;
    int n_total;

    ram_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus ();

    ram_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: combinational read, write committed at the clock edge
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        mem[0] = 8'h5A;
        mem[1] = 8'h11;
        mem[2] = 8'h00;
        mem[3] = 8'h33;
        clr = 1'b0;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 2'd0; bus.wdata0 = 8'h00;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 2'd0; bus.wdata1 = 8'h00;

        // 1. Reset and idle
        #1;
        chk("reset_ctl", {26'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.ram_we}, 32'd0);
        repeat (2) @(posedge clk);
        #1 clr = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_ctl", {26'd0, bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.ram_we}, 32'd0);
            chk("idle_data", {6'd0, bus.rdata0, bus.rdata1, bus.ram_wdata, bus.ram_addr}, 32'd0);
        end

        // 2. Contention: both ports read continuously, port 0 wins first tie
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd1;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd3;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("cont_gnt", {30'd0, bus.gnt0, bus.gnt1}, (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("cont_busy", {31'd0, bus.busy}, 32'd1);
            cyc();
            chk("cont_done", {30'd0, bus.done0, bus.done1}, (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i % 2 == 0) chk("cont_rdata0", {24'd0, bus.rdata0}, 32'h11);
            else            chk("cont_rdata1", {24'd0, bus.rdata1}, 32'h33);
            cyc();
            chk("cont_idle", {29'd0, bus.gnt0, bus.gnt1, bus.busy}, 32'd0);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        // 3. Port 0 write A5 to addr 2, then read it back
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd2; bus.wdata0 = 8'hA5;
        cyc();
        chk("wr_access", {15'd0, bus.gnt0, bus.gnt1, bus.ram_we, bus.busy, bus.ram_addr, bus.ram_wdata, 3'd0},
            {15'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 8'hA5, 3'd0});
        bus.req0 = 1'b0;
        cyc();
        chk("wr_resp", {28'd0, bus.gnt0, bus.ram_we, bus.done0, bus.done1}, 32'd2);
        chk("wr_mem", {24'd0, mem[2]}, 32'hA5);
        cyc();
        chk("wr_end", {29'd0, bus.done0, bus.busy, bus.ram_we}, 32'd0);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd2;
        cyc();
        chk("rd_access", {29'd0, bus.gnt0, bus.gnt1, bus.ram_we}, 32'd4);
        bus.req0 = 1'b0;
        cyc();
        chk("rd_done", {30'd0, bus.done0, bus.done1}, 32'd2);
        chk("rd_data", {24'd0, bus.rdata0}, 32'hA5);
        cyc();

        // 4. Cross-port coherence (port 1 granted last before the tie)
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 2'd0;
        cyc();
        chk("pre_gnt1", {30'd0, bus.gnt0, bus.gnt1}, 32'd1);
        bus.req1 = 1'b0;
        cyc();
        chk("pre_rdata1", {24'd0, bus.rdata1}, 32'h5A);
        cyc();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 2'd0; bus.wdata1 = 8'h3C;
        cyc();
        chk("coh_gnt0", {30'd0, bus.gnt0, bus.gnt1}, 32'd2);
        bus.req0 = 1'b0;
        cyc();
        chk("coh_old", {24'd0, bus.rdata0}, 32'h5A);
        cyc();
        cyc();
        chk("coh_gnt1", {29'd0, bus.gnt0, bus.gnt1, bus.ram_we}, 32'd3);
        bus.req1 = 1'b0;
        cyc();
        chk("coh_done1", {30'd0, bus.done0, bus.done1}, 32'd1);
        chk("coh_rdata1_kept", {24'd0, bus.rdata1}, 32'h5A);
        cyc();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd0;
        cyc();
        bus.req0 = 1'b0;
        cyc();
        chk("coh_new", {24'd0, bus.rdata0}, 32'h3C);
        cyc();

        // 5. Withdrawn request from port 1
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd2;
        cyc();
        chk("wd_gnt0", {30'd0, bus.gnt0, bus.gnt1}, 32'd2);
        bus.req0 = 1'b0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 2'd1; bus.wdata1 = 8'h77;
        cyc();
        chk("wd_resp", {30'd0, bus.done0, bus.done1}, 32'd2);
        bus.req1 = 1'b0;
        cyc();
        chk("wd_idle1", {28'd0, bus.gnt1, bus.done1, bus.busy, bus.ram_we}, 32'd0);
        cyc();
        chk("wd_idle2", {28'd0, bus.gnt1, bus.done1, bus.busy, bus.ram_we}, 32'd0);
        chk("wd_mem", {24'd0, mem[1]}, 32'h11);

        // 6. Reset in the middle of a write's ACCESS cycle
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 2'd3; bus.wdata0 = 8'hFF;
        cyc();
        chk("rst_wr_access", {31'd0, bus.ram_we}, 32'd1);
        bus.req0 = 1'b0;
        #4 clr = 1'b0;
        #1;
        chk("rst_abort", {27'd0, bus.ram_we, bus.gnt0, bus.busy, bus.done0, bus.done1}, 32'd0);
        @(posedge clk);
        #1 clr = 1'b1;
        chk("rst_mem", {24'd0, mem[3]}, 32'h33);
        cyc();
        chk("rst_nodone", {29'd0, bus.done0, bus.busy, bus.gnt0}, 32'd0);
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 2'd3;
        cyc();
        chk("rst_rd_gnt", {31'd0, bus.gnt0}, 32'd1);
        bus.req0 = 1'b0;
        cyc();
        chk("rst_rd_data", {23'd0, bus.done0, bus.rdata0}, {23'd0, 1'b1, 8'h33});
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
